// File: rtl/instr_fetch.sv
// Instruction fetch: keeps the PC, issues one memory read at a time and buffers the returned word for decode.
// Latency: a request is issued one cycle after reset release or consume; instr_valid rises one cycle after rsp_valid.
// Backpressure: req_valid/req_addr hold until req_ready; instr/instr_pc hold until instr_ready; redirect overrides both.
//
// Ports:
//   clk, rst_n                      - clock, asynchronous active-low reset
//   req_valid/req_ready/req_addr    - instruction-memory read request (valid/ready)
//   rsp_valid/rsp_data              - read response, arrives at least one cycle after acceptance
//   instr_valid/instr_ready         - buffered instruction handshake to decode
//   instr/instr_key/instr_pc        - buffered word, its {funct3, opcode} key, and its address
//   redirect/redirect_pc            - one-cycle jump/branch-taken pulse and target
module instr_fetch #(
    parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
    input  logic        clk,
    input  logic        rst_n,
    output logic        req_valid,
    input  logic        req_ready,
    output logic [31:0] req_addr,
    input  logic        rsp_valid,
    input  logic [31:0] rsp_data,
    output logic        instr_valid,
    input  logic        instr_ready,
    output logic [31:0] instr,
    output logic [9:0]  instr_key,
    output logic [31:0] instr_pc,
    input  logic        redirect,
    input  logic [31:0] redirect_pc
);

    typedef enum logic [2:0] {
        ST_IDLE = 3'd0,
        ST_REQ  = 3'd1,
        ST_WAIT = 3'd2,
        ST_HOLD = 3'd3,
        ST_DROP = 3'd4
    } state_t;

    state_t      state_q, state_d;
    logic [31:0] pc_q, pc_d;
    logic [31:0] req_addr_q, req_addr_d;
    logic [31:0] instr_q, instr_d;
    logic [31:0] instr_pc_q, instr_pc_d;
    // Set when the PC was redirected while the current request was still
    // unaccepted: that request must still complete, but its data is junk.
    logic        stale_q, stale_d;
    logic [31:0] redirect_tgt;

    // Word-align the target by masking rather than slicing.
    assign redirect_tgt = redirect_pc & ~32'd3;

    always_comb begin
        state_d    = state_q;
        pc_d       = pc_q;
        req_addr_d = req_addr_q;
        instr_d    = instr_q;
        instr_pc_d = instr_pc_q;
        stale_d    = stale_q;

        // A redirect always retargets the PC, whatever the state.
        if (redirect) begin
            pc_d = redirect_tgt;
        end

        case (state_q)
            ST_IDLE: begin
                state_d = ST_REQ;
                if (redirect) begin
                    stale_d = 1'b1;
                end
            end
            ST_REQ: begin
                if (req_ready) begin
                    state_d = (redirect || stale_q) ? ST_DROP : ST_WAIT;
                    stale_d = 1'b0;
                end else if (redirect) begin
                    stale_d = 1'b1;
                end
            end
            ST_WAIT: begin
                if (redirect) begin
                    // A response coinciding with the redirect is the stale one.
                    state_d = rsp_valid ? ST_REQ : ST_DROP;
                end else if (rsp_valid) begin
                    instr_d    = rsp_data;
                    instr_pc_d = pc_q;
                    state_d    = ST_HOLD;
                end
            end
            ST_HOLD: begin
                if (redirect) begin
                    state_d = ST_REQ;
                end else if (instr_ready) begin
                    pc_d    = pc_q + 32'd4;
                    state_d = ST_REQ;
                end
            end
            ST_DROP: begin
                if (rsp_valid) begin
                    state_d = ST_REQ;
                end
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase

        // Latch a fresh fetch address only when a new request starts; the
        // request out of IDLE reuses the reset address already held.
        if (state_d == ST_REQ && state_q != ST_REQ && state_q != ST_IDLE) begin
            req_addr_d = pc_d;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= ST_IDLE;
            pc_q       <= RESET_PC;
            req_addr_q <= RESET_PC;
            instr_q    <= 32'd0;
            instr_pc_q <= 32'd0;
            stale_q    <= 1'b0;
        end else begin
            state_q    <= state_d;
            pc_q       <= pc_d;
            req_addr_q <= req_addr_d;
            instr_q    <= instr_d;
            instr_pc_q <= instr_pc_d;
            stale_q    <= stale_d;
        end
    end

    assign req_valid   = (state_q == ST_REQ);
    assign instr_valid = (state_q == ST_HOLD);
    assign req_addr    = req_addr_q;
    assign instr       = instr_q;
    assign instr_pc    = instr_pc_q;
    assign instr_key   = {instr_q[14:12], instr_q[6:0]};

endmodule

// File: tb/tb_instr_fetch.sv
module tb_instr_fetch;

    localparam logic [31:0] RESET_PC = 32'h0000_0000;

    logic        clk;
    logic        rst_n;
    logic        req_valid;
    logic        req_ready;
    logic [31:0] req_addr;
    logic        rsp_valid;
    logic [31:0] rsp_data;
    logic        instr_valid;
    logic        instr_ready;
    logic [31:0] instr;
    logic [9:0]  instr_key;
    logic [31:0] instr_pc;
    logic        redirect;
    logic [31:0] redirect_pc;

    instr_fetch #(.RESET_PC(RESET_PC)) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .req_valid   (req_valid),
        .req_ready   (req_ready),
        .req_addr    (req_addr),
        .rsp_valid   (rsp_valid),
        .rsp_data    (rsp_data),
        .instr_valid (instr_valid),
        .instr_ready (instr_ready),
        .instr       (instr),
        .instr_key   (instr_key),
        .instr_pc    (instr_pc),
        .redirect    (redirect),
        .redirect_pc (redirect_pc)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int n_checks = 0;
    int n_pass   = 0;

    typedef struct {
        logic [31:0] addr;
        logic [31:0] data;
    } sb_t;
    sb_t sb[$];

    typedef struct {
        int          rw;     // cycles req_ready held low
        int          lat;    // cycles from acceptance to rsp_valid
        logic [31:0] addr;   // expected fetch address
        logic [31:0] data;   // word returned by memory
        logic [9:0]  key;    // expected {funct3, opcode}
    } vec_t;
    vec_t vecs[4];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %h expected %h", name, act, exp);
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Advance until a request is visible, bounded.
    task automatic wait_req();
        for (int i = 0; i < 20 && !req_valid; i++) step();
        chk("req_seen", {31'd0, req_valid}, 32'd1);
    endtask

    // One complete fetch; with consume=0 it stops with the word in HOLD.
    task automatic fetch(input int rw, input int lat, input logic [31:0] addr,
                         input logic [31:0] data, input logic [9:0] key, input bit consume);
        wait_req();
        chk("req_addr", req_addr, addr);
        req_ready = 1'b0;
        for (int i = 0; i < rw; i++) begin
            step();
            chk("req_hold_valid", {31'd0, req_valid}, 32'd1);
            chk("req_hold_addr", req_addr, addr);
        end
        req_ready = 1'b1;
        step();
        req_ready = 1'b0;
        chk("wait_no_req", {31'd0, req_valid}, 32'd0);
        for (int i = 1; i < lat; i++) step();
        rsp_valid = 1'b1;
        rsp_data  = data;
        step();
        rsp_valid = 1'b0;
        rsp_data  = 32'd0;
        chk("hold_valid", {31'd0, instr_valid}, 32'd1);
        chk("hold_key", {22'd0, instr_key}, {22'd0, key});
        if (consume) begin
            sb.push_back('{addr: addr, data: data});
            instr_ready = 1'b1;
            step();
            instr_ready = 1'b0;
            chk("after_consume_valid", {31'd0, instr_valid}, 32'd0);
        end
    endtask

    // Scoreboard: every instruction actually consumed must be the next expected one.
    always @(negedge clk) begin
        if (rst_n && instr_valid && instr_ready && !redirect) begin
            if (sb.size() == 0) begin
                chk("sb_unexpected_instr", 32'd0, 32'd1);
            end else begin
                sb_t e;
                e = sb.pop_front();
                chk("sb_instr", instr, e.data);
                chk("sb_instr_pc", instr_pc, e.addr);
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish, got timeout expected completion");
        $fatal(1);
    end

    initial begin
        vecs[0] = '{rw: 0, lat: 1, addr: 32'h0000_0000, data: 32'h00A2_8293, key: 10'b000_0010011};
        vecs[1] = '{rw: 0, lat: 1, addr: 32'h0000_0004, data: 32'hFEDC_B0B7, key: 10'b011_0110111};
        vecs[2] = '{rw: 3, lat: 2, addr: 32'h0000_0008, data: 32'h0000_7033, key: 10'b111_0110011};
        vecs[3] = '{rw: 1, lat: 3, addr: 32'h0000_000C, data: 32'h1234_5678, key: 10'b101_1111000};

        rst_n = 1'b0; req_ready = 1'b0; rsp_valid = 1'b0; rsp_data = 32'd0;
        instr_ready = 1'b0; redirect = 1'b0; redirect_pc = 32'd0;
        step(); step();
        chk("rst_req_valid", {31'd0, req_valid}, 32'd0);
        chk("rst_instr_valid", {31'd0, instr_valid}, 32'd0);
        chk("rst_req_addr", req_addr, RESET_PC);
        chk("rst_instr", instr, 32'd0);
        chk("rst_instr_pc", instr_pc, 32'd0);
        chk("rst_instr_key", {22'd0, instr_key}, 32'd0);
        rst_n = 1'b1;

        // Sequential fetches with varying memory stalls.
        for (int v = 0; v < 4; v++)
            fetch(vecs[v].rw, vecs[v].lat, vecs[v].addr, vecs[v].data, vecs[v].key, 1'b1);

        // Redirect in WAIT: the stale response must never reach decode.
        wait_req();
        chk("pre_redir_addr", req_addr, 32'h0000_0010);
        req_ready = 1'b1;
        step();
        req_ready   = 1'b0;
        instr_ready = 1'b1;
        redirect    = 1'b1;
        redirect_pc = 32'h0000_0100;
        step();
        redirect  = 1'b0;
        chk("drop_no_instr", {31'd0, instr_valid}, 32'd0);
        rsp_valid = 1'b1;
        rsp_data  = 32'hDEAD_BEEF;
        step();
        rsp_valid = 1'b0;
        chk("drop_then_req", {31'd0, req_valid}, 32'd1);
        chk("drop_next_addr", req_addr, 32'h0000_0100);
        chk("drop_still_no_instr", {31'd0, instr_valid}, 32'd0);
        instr_ready = 1'b0;

        // Redirect in HOLD beats instr_ready; target low bits cleared.
        fetch(0, 1, 32'h0000_0100, 32'h0000_5067, 10'b101_1100111, 1'b0);
        chk("hold_instr_pc", instr_pc, 32'h0000_0100);
        instr_ready = 1'b1;
        redirect    = 1'b1;
        redirect_pc = 32'h0000_0203;
        step();
        redirect    = 1'b0;
        instr_ready = 1'b0;
        chk("redir_hold_valid", {31'd0, instr_valid}, 32'd0);
        chk("redir_hold_req", {31'd0, req_valid}, 32'd1);
        chk("redir_hold_addr", req_addr, 32'h0000_0200);

        // Redirect while request not accepted: address held, then dropped.
        redirect    = 1'b1;
        redirect_pc = 32'hFFFF_FFFF;
        step();
        redirect = 1'b0;
        chk("unacc_redir_valid", {31'd0, req_valid}, 32'd1);
        chk("unacc_redir_addr", req_addr, 32'h0000_0200);
        req_ready = 1'b1;
        step();
        req_ready   = 1'b0;
        chk("unacc_drop_no_req", {31'd0, req_valid}, 32'd0);
        instr_ready = 1'b1;
        rsp_valid   = 1'b1;
        rsp_data    = 32'hBADB_AD00;
        step();
        rsp_valid   = 1'b0;
        instr_ready = 1'b0;
        chk("unacc_drop_no_instr", {31'd0, instr_valid}, 32'd0);
        chk("top_addr", req_addr, 32'hFFFF_FFFC);

        // PC wrap at the top of the address space.
        fetch(0, 1, 32'hFFFF_FFFC, 32'h0000_2003, 10'b010_0000011, 1'b1);
        fetch(0, 1, 32'h0000_0000, 32'h00A2_8293, 10'b000_0010011, 1'b1);

        // Reset during WAIT.
        wait_req();
        chk("pre_rst_addr", req_addr, 32'h0000_0004);
        req_ready = 1'b1;
        step();
        req_ready = 1'b0;
        rst_n = 1'b0;
        #1;
        chk("arst_req_valid", {31'd0, req_valid}, 32'd0);
        chk("arst_instr_valid", {31'd0, instr_valid}, 32'd0);
        chk("arst_req_addr", req_addr, RESET_PC);
        chk("arst_instr", instr, 32'd0);
        chk("arst_instr_key", {22'd0, instr_key}, 32'd0);
        chk("arst_instr_pc", instr_pc, 32'd0);
        step();
        rst_n       = 1'b1;
        rsp_valid   = 1'b1;
        rsp_data    = 32'hDEAD_BEEF;
        instr_ready = 1'b1;
        step();
        rsp_valid   = 1'b0;
        instr_ready = 1'b0;
        chk("post_rst_req", {31'd0, req_valid}, 32'd1);
        chk("post_rst_addr", req_addr, RESET_PC);
        chk("post_rst_no_instr", {31'd0, instr_valid}, 32'd0);
        fetch(0, 1, RESET_PC, 32'h0000_1023, 10'b001_0100011, 1'b1);

        step(); step();
        chk("sb_drained", sb.size(), 32'd0);
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
